// File: rtl/poc_pkg.sv
// Shared definitions for the PoC instruction front end: address width,
// boot vector, fetch state encoding and per-state strobe decode.
package poc_pkg;

  localparam int         ADDR_W_DEF    = 9;
  localparam logic [8:0] RESET_VEC_DEF = 9'd0;

  typedef enum logic [2:0] {
    FS_BOOT  = 3'd0,
    FS_IDLE  = 3'd1,
    FS_JUMP  = 3'd2,
    FS_LOAD  = 3'd3,
    FS_READ1 = 3'd4,
    FS_NEXT  = 3'd5,
    FS_READ2 = 3'd6,
    FS_VALID = 3'd7
  } fetch_state_e;

  typedef struct packed {
    logic pc_write;
    logic pc_inc;
    logic iar_write;
    logic iar_inc;
    logic idr_write;
    logic instr_valid;
  } fetch_strobe_t;

  // Moore decode: every strobe is a pure function of the current state.
  function automatic fetch_strobe_t decode_strobes(input fetch_state_e s);
    fetch_strobe_t st;
    st = '0;
    case (s)
      FS_BOOT:  st.pc_write    = 1'b1;
      FS_JUMP:  st.pc_write    = 1'b1;
      FS_LOAD:  begin
        st.iar_write = 1'b1;
        st.pc_inc    = 1'b1;
      end
      FS_READ1: st.idr_write   = 1'b1;
      FS_NEXT:  begin
        st.iar_inc = 1'b1;
        st.pc_inc  = 1'b1;
      end
      FS_READ2: st.idr_write   = 1'b1;
      FS_VALID: st.instr_valid = 1'b1;
      default:  ;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/poc_fetch_perf.sv
// Fetch performance counters: completed instructions and 2-word
// instructions seen. Both are free-running 16-bit and wrap.
module poc_fetch_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_done,
  input  logic        long_seen,
  output logic [15:0] instr_cnt,
  output logic [15:0] long_cnt
);

  // Count instructions handed to the control unit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             instr_cnt <= '0;
    else if (instr_done) instr_cnt <= instr_cnt + 16'd1;
  end

  // Count 2-word instructions detected at the first read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            long_cnt <= '0;
    else if (long_seen) long_cnt <= long_cnt + 16'd1;
  end

endmodule

// File: rtl/poc_fetch_ctrl.sv
// Fetch sequencer: moves one 1- or 2-word instruction from IRAM into IDR
// by strobing PC/IAR/IDR, and serves PC loads for jumps and the boot vector.
// Optional macro POC_FETCH_PERF_EN adds instr_cnt/long_cnt counter ports.
//
// state | meaning
// BOOT  | load PC with RESET_VEC
// IDLE  | wait for jump_en (priority) or fetch_req
// JUMP  | load PC with captured jump target
// LOAD  | IAR <- PC, PC++
// READ1 | IDR <- first word, sample long_instr
// NEXT  | IAR++, PC++ for second word
// READ2 | IDR <- second word
// VALID | instruction ready, wait for instr_ack
module poc_fetch_ctrl
  import poc_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic              instr_ack,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              long_instr,
  output logic              pc_write,
  output logic              pc_inc,
  output logic [ADDR_W-1:0] pc_din,
  output logic              iar_write,
  output logic              iar_inc,
  output logic              idr_write,
  output logic              instr_valid,
  output logic              busy
`ifdef POC_FETCH_PERF_EN
  ,
  output logic [15:0]       instr_cnt,
  output logic [15:0]       long_cnt
`endif
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] jaddr_q;
  fetch_strobe_t     strb;

  // State register; reset always restarts from the boot vector load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FS_BOOT;
    else     state_q <= state_d;
  end

  // Jump target is latched only when the jump is accepted in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                jaddr_q <= '0;
    else if (state_q == FS_IDLE && jump_en) jaddr_q <= jump_addr;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FS_BOOT:  state_d = FS_IDLE;
      FS_IDLE: begin
        if (jump_en)        state_d = FS_JUMP;
        else if (fetch_req) state_d = FS_LOAD;
      end
      FS_JUMP:  state_d = FS_IDLE;
      FS_LOAD:  state_d = FS_READ1;
      FS_READ1: state_d = long_instr ? FS_NEXT : FS_VALID;
      FS_NEXT:  state_d = FS_READ2;
      FS_READ2: state_d = FS_VALID;
      FS_VALID: if (instr_ack) state_d = FS_IDLE;
      default:  state_d = FS_BOOT;
    endcase
  end

  // Output decode; reset forces strobes low at once, even though the
  // register already sits in BOOT (which would otherwise drive pc_write).
  always_comb begin
    strb = decode_strobes(state_q);
    if (rst) strb = '0;
  end

  assign pc_write    = strb.pc_write;
  assign pc_inc      = strb.pc_inc;
  assign iar_write   = strb.iar_write;
  assign iar_inc     = strb.iar_inc;
  assign idr_write   = strb.idr_write;
  assign instr_valid = strb.instr_valid;
  assign busy        = (state_q != FS_IDLE);
  assign pc_din      = (state_q == FS_BOOT) ? RESET_VEC : jaddr_q;

`ifdef POC_FETCH_PERF_EN
  logic instr_done, long_seen;
  assign instr_done = (state_q == FS_VALID) && instr_ack;
  assign long_seen  = (state_q == FS_READ1) && long_instr;

  poc_fetch_perf u_perf (
    .clk        (clk),
    .rst        (rst),
    .instr_done (instr_done),
    .long_seen  (long_seen),
    .instr_cnt  (instr_cnt),
    .long_cnt   (long_cnt)
  );
`endif

endmodule
